// File: rtl/ldpc_enc_pkg.sv
// Shared types and constants for the LDPC encoder control slice.
// Optional macro LDPC_ENC_BACKPRESSURE_EN is consumed by ldpc_enc_ctrl.
package ldpc_enc_pkg;

  localparam int CNT_W = 13;
  localparam int ADDR_W = 12;
  localparam int K_R12 = 2304;
  localparam int K_R34 = 3456;
  localparam int N_LEN = 4608;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_DATA_I = 4'b0010,
    S_PAR_C  = 4'b0100,
    S_DATA_O = 4'b1000
  } state_t;

  function automatic logic [CNT_W-1:0] k_of(input logic rate);
    return rate ? CNT_W'(K_R34) : CNT_W'(K_R12);
  endfunction

endpackage

// File: rtl/ldpc_enc_dly.sv
// Fixed-latency shift register aligning parity write strobe and row
// index with the parity datapath pipeline.
module ldpc_enc_dly
  import ldpc_enc_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic [ADDR_W-1:0] waddr
);

  logic [LAT-1:0]    v;
  logic [ADDR_W-1:0] a [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) a[i] <= '0;
    end else begin
      v[0] <= en;
      a[0] <= addr;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        a[i] <= a[i-1];
      end
    end
  end

  assign we = v[LAT-1];
  assign waddr = a[LAT-1];

endmodule

// File: rtl/ldpc_enc_ctrl.sv
// LDPC encoder control: message framing, parity sequencing, codeword out.
// Define LDPC_ENC_BACKPRESSURE_EN to add out_ready flow control on output.
module ldpc_enc_ctrl
  import ldpc_enc_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync_in,
  input  logic              rate,
`ifdef LDPC_ENC_BACKPRESSURE_EN
  input  logic              out_ready,
`endif
  output logic              msg_we,
  output logic [ADDR_W-1:0] msg_addr,
  output logic              par_en,
  output logic [ADDR_W-1:0] par_addr,
  output logic              par_we,
  output logic [ADDR_W-1:0] par_waddr,
  output logic              out_rd,
  output logic              out_sel,
  output logic [ADDR_W-1:0] out_addr,
  output logic              sync_out,
  output logic              busy,
  output logic              finish,
  output logic              err_len,
  output logic [3:0]        fsm_state
);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] k, m, rel;
  logic             rate_q;
  logic             fin_q, fin_nxt;
  logic             adv;

`ifdef LDPC_ENC_BACKPRESSURE_EN
  assign adv = out_ready;
`else
  assign adv = 1'b1;
`endif

  assign k = k_of(rate_q);
  assign m = CNT_W'(N_LEN) - k;
  assign rel = cnt - k;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      rate_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      fin_q <= fin_nxt;
      if (state == S_IDLE && sync_in) rate_q <= rate;
    end
  end

  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    fin_nxt = 1'b0;
    msg_we = 1'b0;
    msg_addr = '0;
    par_en = 1'b0;
    par_addr = '0;
    out_rd = 1'b0;
    out_sel = 1'b0;
    out_addr = '0;
    sync_out = 1'b0;
    err_len = 1'b0;
    unique case (1'b1)
      state[0]: begin
        cnt_nxt = '0;
        if (sync_in) begin
          msg_we = 1'b1;
          nxt = S_DATA_I;
          cnt_nxt = CNT_W'(1);
        end
      end
      state[1]: begin
        if (sync_in) begin
          msg_we = 1'b1;
          msg_addr = cnt[ADDR_W-1:0];
          if (cnt == k - CNT_W'(1)) begin
            nxt = S_PAR_C;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          err_len = 1'b1;
          nxt = S_IDLE;
          cnt_nxt = '0;
        end
      end
      state[2]: begin
        par_en = (cnt < m);
        par_addr = par_en ? cnt[ADDR_W-1:0] : '0;
        // Only a bit arriving right after bit K-1 is a long-frame error.
        err_len = (cnt == '0) && sync_in;
        if (cnt == m + CNT_W'(PIPE_LAT - 1)) begin
          nxt = S_DATA_O;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      state[3]: begin
        sync_out = 1'b1;
        out_rd = adv;
        out_sel = (cnt >= k);
        out_addr = out_sel ? rel[ADDR_W-1:0] : cnt[ADDR_W-1:0];
        if (adv) begin
          if (cnt == CNT_W'(N_LEN - 1)) begin
            nxt = S_IDLE;
            cnt_nxt = '0;
            fin_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        nxt = S_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  ldpc_enc_dly #(.LAT(PIPE_LAT)) u_dly (
    .clk   (clk),
    .reset (reset),
    .en    (par_en),
    .addr  (par_addr),
    .we    (par_we),
    .waddr (par_waddr)
  );

  assign busy = (state != S_IDLE);
  assign finish = fin_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// Scoreboard bench for ldpc_enc_ctrl with a frame-level reference model.
// Honours LDPC_ENC_BACKPRESSURE_EN when the design is built with it.
module tb_ldpc_enc_ctrl;

  localparam int NL = 4608;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sync_in = 1'b0;
  logic rate = 1'b0;
  logic out_ready = 1'b1;
  logic msg_we, par_en, par_we, out_rd, out_sel;
  logic sync_out, busy, finish, err_len;
  logic [11:0] msg_addr, par_addr, par_waddr, out_addr;
  logic [3:0] fsm_state;

  ldpc_enc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (sync_in),
    .rate      (rate),
`ifdef LDPC_ENC_BACKPRESSURE_EN
    .out_ready (out_ready),
`endif
    .msg_we    (msg_we),
    .msg_addr  (msg_addr),
    .par_en    (par_en),
    .par_addr  (par_addr),
    .par_we    (par_we),
    .par_waddr (par_waddr),
    .out_rd    (out_rd),
    .out_sel   (out_sel),
    .out_addr  (out_addr),
    .sync_out  (sync_out),
    .busy      (busy),
    .finish    (finish),
    .err_len   (err_len),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int q_msg[$], q_par[$], q_pwe[$], q_out[$], pen_t[$];
  int err_seen, fin_seen, exp_err, exp_fin;
  int stall_exp = 0;
  int so_start = 0, last_rd = 0;
  logic so_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected transactions whenever the DUT presents one.
  always @(negedge clk) begin
    if (msg_we) begin
      if (q_msg.size() == 0) chk("msg_we_extra", 1, 0);
      else chk("msg_addr", int'(msg_addr), q_msg.pop_front());
    end
    if (par_en) begin
      pen_t.push_back(cyc);
      if (q_par.size() == 0) chk("par_en_extra", 1, 0);
      else chk("par_addr", int'(par_addr), q_par.pop_front());
    end
    if (par_we) begin
      if (q_pwe.size() == 0) chk("par_we_extra", 1, 0);
      else chk("par_waddr", int'(par_waddr), q_pwe.pop_front());
      if (pen_t.size() == 0) chk("par_we_orphan", 1, 0);
      else chk("par_lat", cyc - pen_t.pop_front(), LAT);
    end
    if (out_rd) begin
      chk("sync_with_rd", int'(sync_out), 1);
      if (q_out.size() == 0) chk("out_rd_extra", 1, 0);
      else chk("out_word", int'({out_sel, out_addr}), q_out.pop_front());
      last_rd = cyc;
    end else if (sync_out) begin
      if (q_out.size() == 0) chk("stall_extra", 1, 0);
      else chk("stall_hold", int'({out_sel, out_addr}), q_out[0]);
    end
    if (sync_out && !so_prev) so_start = cyc;
    so_prev = sync_out;
    if (err_len) err_seen++;
    if (finish) begin
      fin_seen++;
      chk("fin_after_last", cyc - last_rd, 1);
      chk("fin_sync_len", cyc - so_start, NL + stall_exp);
    end
  end

  // Reference model: what one frame of length len at rate r must produce.
  task automatic build_expect(input bit r, input int len);
    int k, m, n;
    k = r ? 3456 : 2304;
    m = NL - k;
    n = (len < k) ? len : k;
    for (int i = 0; i < n; i++) q_msg.push_back(i);
    if (len < k) begin
      exp_err = 1;
      exp_fin = 0;
    end else begin
      exp_err = (len > k) ? 1 : 0;
      exp_fin = 1;
      for (int i = 0; i < m; i++) begin
        q_par.push_back(i);
        q_pwe.push_back(i);
      end
      for (int j = 0; j < NL; j++)
        q_out.push_back(j < k ? j : (4096 + j - k));
    end
  endtask

  task automatic drive_frame(input bit r, input int len, input bit tog);
    err_seen = 0;
    fin_seen = 0;
    build_expect(r, len);
    @(posedge clk) #1;
    sync_in = 1'b1;
    rate = r;
    for (int i = 0; i < len; i++) begin
      @(posedge clk) #1;
      if (i == 0) chk("busy_set", int'(busy), 1);
      if (tog) rate = 1'($urandom);
    end
    sync_in = 1'b0;
  endtask

  task automatic wait_idle_and_check(input string nm);
    bit done = 0;
    for (int t = 0; t < 12000; t++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    chk({nm, "_err"}, err_seen, exp_err);
    chk({nm, "_fin"}, fin_seen, exp_fin);
    chk({nm, "_q_left"}, q_msg.size() + q_par.size() + q_pwe.size() + q_out.size(), 0);
    chk({nm, "_idle"}, int'(fsm_state), 1);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  task automatic run_frame(input string nm, input bit r, input int len,
                           input bit tog, input bit stall);
    stall_exp = 0;
`ifdef LDPC_ENC_BACKPRESSURE_EN
    if (stall) stall_exp = 5;
`endif
    drive_frame(r, len, tog);
`ifdef LDPC_ENC_BACKPRESSURE_EN
    if (stall) begin
      bit seen = 0;
      for (int t = 0; t < 12000; t++) begin
        @(negedge clk);
        if (sync_out) begin
          seen = 1;
          break;
        end
      end
      if (!seen) chk({nm, "_no_sync_out"}, 0, 1);
      repeat (100) @(posedge clk) #1;
      out_ready = 1'b0;
      repeat (5) @(posedge clk) #1;
      out_ready = 1'b1;
    end
`else
    if (stall) stall_exp = 0;
`endif
    wait_idle_and_check(nm);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_state"}, int'(fsm_state), 1);
    chk({nm, "_outs"}, int'({msg_we, par_en, par_we, out_rd, out_sel,
        sync_out, busy, finish, err_len}), 0);
    chk({nm, "_addrs"}, int'(msg_addr | par_addr | out_addr), 0);
  endtask

  initial begin
    int lr, kr;
    bit rr;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    run_frame("r12", 1'b0, 2304, 1'b0, 1'b1);
    run_frame("r34_tog", 1'b1, 3456, 1'b1, 1'b0);
    run_frame("short", 1'b0, 100, 1'b0, 1'b0);
    run_frame("long", 1'b0, 2310, 1'b0, 1'b0);

    // Abort in the middle of parity computation.
    stall_exp = 0;
    drive_frame(1'b0, 2304, 1'b0);
    repeat (500) @(posedge clk) #1;
    chk("pre_reset_parc", int'(fsm_state), 4);
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    q_msg.delete();
    q_par.delete();
    q_pwe.delete();
    q_out.delete();
    pen_t.delete();
    @(negedge clk);
    check_quiet("mid_reset");
    chk("mid_reset_fin", fin_seen, 0);
    run_frame("after_reset", 1'b1, 3456, 1'b0, 1'b0);

    rr = 1'($urandom);
    kr = rr ? 3456 : 2304;
    lr = $urandom_range(kr - 1, 1);
    run_frame("rnd_short", rr, lr, 1'b1, 1'b0);
    rr = 1'($urandom);
    kr = rr ? 3456 : 2304;
    lr = kr + $urandom_range(4, 0);
    run_frame("rnd_full", rr, lr, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
